// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and the IF/ID field bundle
// used by the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned PC_WIDTH  = 16;
   localparam int unsigned OPCODE_W  = 4;
   localparam int unsigned OPERAND_W = 3;
   localparam int unsigned IMM_W     = 8;
   localparam int unsigned BR_OFF_W  = 8;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned PROG_LEN  = 35;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   typedef struct packed {
      logic                 format;
      logic [OPCODE_W-1:0]  opcode;
      logic                 sign;
      logic [OPERAND_W-1:0] operand;
      logic [IMM_W-1:0]     immediate;
   } instr_t;

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the fetch stage
// (sequential increment, IR-relative branch, absolute branch).
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH = fetch_pkg::PC_WIDTH
) (
   input  logic [PC_WIDTH-1:0] pc_i,
   input  logic [PC_WIDTH-1:0] ir_pc_i,
   input  logic                redirect_i,
   input  logic                abs_i,
   input  logic [BR_OFF_W-1:0] offset_i,
   input  logic [PC_WIDTH-1:0] target_i,
   output logic [PC_WIDTH-1:0] pc_o
);

   logic [PC_WIDTH-1:0] off_ext;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] rel_pc;

   // Relative targets are taken from the branch's own address, not the
   // wrong-path PC that has already advanced past it.
   always_comb begin
      off_ext = {{(PC_WIDTH-BR_OFF_W){offset_i[BR_OFF_W-1]}}, offset_i};
      seq_pc  = pc_i + PC_WIDTH'(1);
      rel_pc  = ir_pc_i + off_ext + PC_WIDTH'(1);
      pc_o    = seq_pc;
      if (redirect_i) begin
         pc_o = abs_i ? target_i : rel_pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC that drives instr_rom_1 and
// latching the ROM's decoded fields into the IF/ID register.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned         PC_WIDTH = fetch_pkg::PC_WIDTH,
   parameter int unsigned         PROG_LEN = fetch_pkg::PROG_LEN,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 halt_req,
   input  logic                 branch_taken,
   input  logic                 branch_absolute,
   input  logic [BR_OFF_W-1:0]  branch_offset,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 rom_format,
   input  logic [OPCODE_W-1:0]  rom_opcode,
   input  logic                 rom_sign,
   input  logic [OPERAND_W-1:0] rom_operand,
   input  logic [IMM_W-1:0]     rom_immediate,
   output logic [PC_WIDTH-1:0]  pc_out,
   output logic                 ir_valid,
   output logic                 ir_format,
   output logic [OPCODE_W-1:0]  ir_opcode,
   output logic                 ir_sign,
   output logic [OPERAND_W-1:0] ir_operand,
   output logic [IMM_W-1:0]     ir_immediate,
   output logic [PC_WIDTH-1:0]  ir_pc,
   output logic                 halted,
   output logic [CNT_W-1:0]     cycle_count
);

   state_e              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic [PC_WIDTH-1:0] ir_pc_q;
   logic                ir_valid_q;
   logic                halted_q;
   instr_t              ir_q;
   logic [CNT_W-1:0]    cycle_q;
   logic                redirect;
   logic                past_end;

   // A branch only counts when the IR holds the instruction it belongs to.
   assign redirect = branch_taken & ir_valid_q;
   assign past_end = 32'(pc_q) >= PROG_LEN;

   fetch_next_pc #(
      .PC_WIDTH (PC_WIDTH)
   ) u_next_pc (
      .pc_i       (pc_q),
      .ir_pc_i    (ir_pc_q),
      .redirect_i (redirect),
      .abs_i      (branch_absolute),
      .offset_i   (branch_offset),
      .target_i   (branch_target),
      .pc_o       (pc_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_pc_q    <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         cycle_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (cycle_q != '1) begin
                  cycle_q <= cycle_q + CNT_W'(1);
               end
               if (halt_req || past_end) begin
                  state_q    <= HALT;
                  halted_q   <= 1'b1;
                  ir_valid_q <= 1'b0;
               end else if (redirect) begin
                  pc_q       <= pc_d;
                  ir_valid_q <= 1'b0;
               end else if (!stall) begin
                  ir_q       <= {rom_format, rom_opcode, rom_sign,
                                 rom_operand, rom_immediate};
                  ir_pc_q    <= pc_q;
                  ir_valid_q <= 1'b1;
                  pc_q       <= pc_d;
               end
            end
            HALT: begin
               halted_q   <= 1'b1;
               ir_valid_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pc_out       = pc_q;
   assign ir_valid     = ir_valid_q;
   assign ir_format    = ir_q.format;
   assign ir_opcode    = ir_q.opcode;
   assign ir_sign      = ir_q.sign;
   assign ir_operand   = ir_q.operand;
   assign ir_immediate = ir_q.immediate;
   assign ir_pc        = ir_pc_q;
   assign halted       = halted_q;
   assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the fetch stage.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, stall, halt_req;
   logic        branch_taken, branch_absolute;
   logic [7:0]  branch_offset;
   logic [15:0] branch_target;
   logic        rom_format, rom_sign;
   logic [3:0]  rom_opcode;
   logic [2:0]  rom_operand;
   logic [7:0]  rom_immediate;

   logic [15:0] pc_out, ir_pc, cycle_count;
   logic        ir_valid, ir_format, ir_sign, halted;
   logic [3:0]  ir_opcode;
   logic [2:0]  ir_operand;
   logic [7:0]  ir_immediate;

   logic [15:0] w_pc, w_ir_pc, w_cyc;
   logic        w_valid, w_format, w_sign, w_halted;
   logic [3:0]  w_opcode;
   logic [2:0]  w_operand;
   logic [7:0]  w_imm;

   instr_t rom_mem [64];
   instr_t dut_ir;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   assign {rom_format, rom_opcode, rom_sign, rom_operand, rom_immediate}
      = rom_mem[pc_out[5:0]];
   assign dut_ir = {ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate};

   fetch_unit u_dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .halt_req(halt_req), .branch_taken(branch_taken),
      .branch_absolute(branch_absolute), .branch_offset(branch_offset),
      .branch_target(branch_target), .rom_format(rom_format),
      .rom_opcode(rom_opcode), .rom_sign(rom_sign),
      .rom_operand(rom_operand), .rom_immediate(rom_immediate),
      .pc_out(pc_out), .ir_valid(ir_valid), .ir_format(ir_format),
      .ir_opcode(ir_opcode), .ir_sign(ir_sign), .ir_operand(ir_operand),
      .ir_immediate(ir_immediate), .ir_pc(ir_pc), .halted(halted),
      .cycle_count(cycle_count)
   );

   fetch_unit #(
      .PROG_LEN (65536),
      .RESET_PC (16'hFFFF)
   ) u_wrap (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .halt_req(halt_req), .branch_taken(branch_taken),
      .branch_absolute(branch_absolute), .branch_offset(branch_offset),
      .branch_target(branch_target), .rom_format(rom_format),
      .rom_opcode(rom_opcode), .rom_sign(rom_sign),
      .rom_operand(rom_operand), .rom_immediate(rom_immediate),
      .pc_out(w_pc), .ir_valid(w_valid), .ir_format(w_format),
      .ir_opcode(w_opcode), .ir_sign(w_sign), .ir_operand(w_operand),
      .ir_immediate(w_imm), .ir_pc(w_ir_pc), .halted(w_halted),
      .cycle_count(w_cyc)
   );

   typedef struct {
      logic        start, stall, hreq, br, babs;
      logic [7:0]  off;
      logic [15:0] tgt;
      logic [15:0] pc;
      logic        v;
      logic [15:0] irpc;
      logic        hlt;
      logic [15:0] cyc;
      instr_t      ir;
   } vec_t;

   vec_t tbl [20];

   // behavioural model: 0 idle, 1 running, 2 halted
   int     m_st, m_pc, m_valid, m_ir_pc, m_cyc;
   instr_t m_ir;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stall = 0; halt_req = 0;
      branch_taken = 0; branch_absolute = 0;
      branch_offset = '0; branch_target = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   function automatic vec_t mk(logic s, logic st, logic hr, logic b,
                               logic ba, logic [7:0] o, logic [15:0] t,
                               int pc, int v, int irpc, int cyc, int fet);
      vec_t r;
      r.start = s; r.stall = st; r.hreq = hr; r.br = b; r.babs = ba;
      r.off = o; r.tgt = t;
      r.pc = 16'(pc); r.v = v[0]; r.irpc = 16'(irpc);
      r.hlt = 1'b0; r.cyc = 16'(cyc);
      r.ir = (fet != 0) ? rom_mem[irpc % 64] : '0;
      return r;
   endfunction

   task automatic model_reset();
      m_st = 0; m_pc = 0; m_valid = 0; m_ir_pc = 0; m_cyc = 0;
      m_ir = '0;
   endtask

   task automatic model_step();
      if (m_st == 0) begin
         if (start) m_st = 1;
      end else if (m_st == 1) begin
         if (m_cyc < 65535) m_cyc++;
         if (halt_req || m_pc >= 35) begin
            m_st = 2;
            m_valid = 0;
         end else if (branch_taken && m_valid != 0) begin
            if (branch_absolute)
               m_pc = int'(branch_target);
            else
               m_pc = (m_ir_pc + 1 + int'($signed(branch_offset))) & 32'hFFFF;
            m_valid = 0;
         end else if (!stall) begin
            m_ir    = rom_mem[m_pc % 64];
            m_ir_pc = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) & 32'hFFFF;
         end
      end
   endtask

   task automatic model_check(input int cyc);
      chk($sformatf("rnd_pc@%0d", cyc), pc_out, m_pc);
      chk($sformatf("rnd_valid@%0d", cyc), ir_valid, m_valid);
      chk($sformatf("rnd_halted@%0d", cyc), halted, (m_st == 2));
      chk($sformatf("rnd_cycles@%0d", cyc), cycle_count, m_cyc);
      chk($sformatf("rnd_irpc@%0d", cyc), ir_pc, m_ir_pc);
      chk($sformatf("rnd_ir@%0d", cyc), dut_ir, m_ir);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      idle_inputs();

      rom_mem[0] = {1'b0, 4'b0000, 1'b0, 3'b001, 8'h01};
      rom_mem[1] = {1'b1, 4'b0001, 1'b0, 3'b000, 8'h10};
      for (int i = 2; i < 64; i++) rom_mem[i] = 17'($urandom);

      // reset state and PC wrap from 0xFFFF on the second instance
      do_reset();
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_valid", ir_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_cycles", cycle_count, 16'h0000);
      chk("rst_ir", dut_ir, 17'h0);
      chk("wrap_rst_pc", w_pc, 16'hFFFF);
      start = 1; tick(); start = 0;
      chk("wrap_start_pc", w_pc, 16'hFFFF);
      chk("wrap_start_valid", w_valid, 1'b0);
      tick();
      chk("wrap_pc", w_pc, 16'h0000);
      chk("wrap_irpc", w_ir_pc, 16'hFFFF);
      chk("wrap_valid", w_valid, 1'b1);

      // vector table
      tbl[0]  = mk(1,0,0,0,0,8'h00,16'h0000,  0,0, 0, 0,0);
      tbl[1]  = mk(0,0,0,0,0,8'h00,16'h0000,  1,1, 0, 1,1);
      tbl[2]  = mk(0,0,0,0,0,8'h00,16'h0000,  2,1, 1, 2,1);
      tbl[3]  = mk(0,0,0,0,0,8'h00,16'h0000,  3,1, 2, 3,1);
      tbl[4]  = mk(0,0,0,0,0,8'h00,16'h0000,  4,1, 3, 4,1);
      tbl[5]  = mk(0,0,0,0,0,8'h00,16'h0000,  5,1, 4, 5,1);
      tbl[6]  = mk(0,1,0,0,0,8'h00,16'h0000,  5,1, 4, 6,1);
      tbl[7]  = mk(0,1,0,0,0,8'h00,16'h0000,  5,1, 4, 7,1);
      tbl[8]  = mk(0,1,0,0,0,8'h00,16'h0000,  5,1, 4, 8,1);
      tbl[9]  = mk(0,0,0,0,0,8'h00,16'h0000,  6,1, 5, 9,1);
      tbl[10] = mk(0,0,0,0,0,8'h00,16'h0000,  7,1, 6,10,1);
      tbl[11] = mk(0,0,0,0,0,8'h00,16'h0000,  8,1, 7,11,1);
      tbl[12] = mk(0,0,0,0,0,8'h00,16'h0000,  9,1, 8,12,1);
      tbl[13] = mk(0,0,0,0,0,8'h00,16'h0000, 10,1, 9,13,1);
      tbl[14] = mk(0,0,0,0,0,8'h00,16'h0000, 11,1,10,14,1);
      tbl[15] = mk(0,1,0,1,0,8'hFB,16'h0000,  6,0,10,15,1);
      tbl[16] = mk(0,0,0,0,0,8'h00,16'h0000,  7,1, 6,16,1);
      tbl[17] = mk(0,0,0,1,1,8'h00,16'h0014, 20,0, 6,17,1);
      tbl[18] = mk(0,0,0,1,0,8'h7F,16'h0000, 21,1,20,18,1);
      tbl[19] = mk(1,0,0,0,0,8'h00,16'h0000, 22,1,21,19,1);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         start = tbl[i].start; stall = tbl[i].stall;
         halt_req = tbl[i].hreq; branch_taken = tbl[i].br;
         branch_absolute = tbl[i].babs; branch_offset = tbl[i].off;
         branch_target = tbl[i].tgt;
         tick();
         chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].pc);
         chk($sformatf("vec%0d_valid", i), ir_valid, tbl[i].v);
         chk($sformatf("vec%0d_irpc", i), ir_pc, tbl[i].irpc);
         chk($sformatf("vec%0d_halted", i), halted, tbl[i].hlt);
         chk($sformatf("vec%0d_cycles", i), cycle_count, tbl[i].cyc);
         chk($sformatf("vec%0d_ir", i), dut_ir, tbl[i].ir);
         if (i == 1) begin
            chk("first_opcode", ir_opcode, 4'b0000);
            chk("first_operand", ir_operand, 3'b001);
            chk("first_imm", ir_immediate, 8'h01);
         end
         if (i == 2) begin
            chk("second_format", ir_format, 1'b1);
            chk("second_opcode", ir_opcode, 4'b0001);
            chk("second_imm", ir_immediate, 8'h10);
         end
      end
      idle_inputs();

      // free run to end of program
      n = 0;
      while (pc_out != 16'd35 && n < 60) begin
         tick();
         n++;
      end
      chk("end_timeout", (n < 60), 1'b1);
      chk("end_last_irpc", ir_pc, 16'd34);
      chk("end_last_valid", ir_valid, 1'b1);
      tick();
      chk("end_halted", halted, 1'b1);
      chk("end_valid", ir_valid, 1'b0);
      chk("end_pc", pc_out, 16'd35);
      start = 1; stall = 1; branch_taken = 1;
      branch_absolute = 1; branch_target = 16'h0003;
      tick();
      tick();
      idle_inputs();
      chk("halt_sticky", halted, 1'b1);
      chk("halt_pc_hold", pc_out, 16'd35);
      chk("halt_valid", ir_valid, 1'b0);
      chk("halt_cycles", cycle_count, 16'd33);

      // asynchronous reset in the middle of a run
      do_reset();
      start = 1; tick(); start = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("mid_pc12", pc_out, 16'd12);
      reset = 1'b1;
      #1;
      chk("async_pc", pc_out, 16'd0);
      chk("async_valid", ir_valid, 1'b0);
      chk("async_halted", halted, 1'b0);
      chk("async_cycles", cycle_count, 16'd0);
      chk("async_irpc", ir_pc, 16'd0);
      #1 reset = 1'b0;
      tick();
      chk("idle_pc_hold", pc_out, 16'd0);
      chk("idle_cycles", cycle_count, 16'd0);
      start = 1; tick(); start = 0;
      tick();
      chk("restart_pc", pc_out, 16'd1);
      chk("restart_valid", ir_valid, 1'b1);

      // halt request beats a simultaneous branch
      do_reset();
      start = 1; tick(); start = 0;
      tick(); tick(); tick();
      chk("hb_pre_pc", pc_out, 16'd3);
      halt_req = 1; branch_taken = 1;
      branch_absolute = 1; branch_target = 16'h0020;
      tick();
      idle_inputs();
      chk("hb_halted", halted, 1'b1);
      chk("hb_pc", pc_out, 16'd3);
      chk("hb_valid", ir_valid, 1'b0);

      // randomized episodes against the model
      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         model_reset();
         for (int c = 0; c < 120; c++) begin
            start           = ($urandom_range(0, 3) == 0);
            stall           = ($urandom_range(0, 99) < 30);
            halt_req        = ($urandom_range(0, 199) < 3);
            branch_taken    = ($urandom_range(0, 99) < 15);
            branch_absolute = $urandom_range(0, 1) != 0;
            branch_offset   = 8'($urandom_range(0, 15)) - 8'd8;
            branch_target   = 16'($urandom_range(0, 40));
            model_step();
            tick();
            model_check(ep * 1000 + c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
